// File: rtl/gb_clk_pkg.sv
// gb_clk_pkg: shared state enum and rate/timing defaults for the Game Boy clock-enable generator.
package gb_clk_pkg;
    typedef enum logic {RUN, STALL} state_e;
    localparam int unsigned INC_2X = 32'd555999952;
    localparam int unsigned INC_1X = 32'd277999976;
    localparam int STALL_TICKS_DEF = 8200;
    localparam int RST_TICKS_DEF = 1024;
endpackage

// File: rtl/gb_frac_ce.sv
// gb_frac_ce: fractional phase accumulator producing a raw carry, frozen while paused.
module gb_frac_ce #(
    parameter int ACC_W = 32,
    parameter logic [ACC_W-1:0] INC = ACC_W'(gb_clk_pkg::INC_2X)
) (
    input  logic clk,
    input  logic reset,
    input  logic pause_i,
    output logic carry_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0] sum;
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, INC};
        carry_o = ~pause_i & sum[ACC_W];
        acc_d = pause_i ? acc_q : sum[ACC_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else acc_q <= acc_d;
    end
endmodule

// File: rtl/gb_clk_enable.sv
// gb_clk_enable: derives ce/ce_n/ce_2x/cpu_ce from the system clock, sequences CGB
// speed switches and stretches the core reset.
module gb_clk_enable
    import gb_clk_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter logic [ACC_W-1:0] INC = ACC_W'(INC_2X),
    parameter int STALL_TICKS = STALL_TICKS_DEF,
    parameter int RST_TICKS = RST_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pause,
    input  logic switch_req,
    output logic ce_2x,
    output logic ce,
    output logic ce_n,
    output logic cpu_ce,
    output logic double_speed,
    output logic switch_done,
    output logic gb_reset
);
    state_e state_q, state_d;
    logic carry, phase_q, accept, stall_end;
    logic ce_2x_q, ce_q, ce_n_q, cpu_ce_q, cpu_ce_d, ds_q, ds_d, done_q;
    logic [15:0] stall_cnt_q, stall_cnt_d, rst_cnt_q, rst_cnt_d;

    gb_frac_ce #(.ACC_W(ACC_W), .INC(INC)) u_frac (
        .clk(clk), .reset(reset), .pause_i(pause), .carry_o(carry)
    );

    // Counters advance on the registered ce pulse, so pause freezes them implicitly.
    always_comb begin
        accept = state_q == RUN && switch_req && rst_cnt_q == '0;
        stall_end = state_q == STALL && ce_q && stall_cnt_q <= 16'd1;
        state_d = accept ? STALL : stall_end ? RUN : state_q;
        stall_cnt_d = accept ? 16'(STALL_TICKS)
                    : (state_q == STALL && ce_q) ? stall_cnt_q - 16'd1 : stall_cnt_q;
        ds_d = stall_end ? ~ds_q : ds_q;
        rst_cnt_d = (ce_q && rst_cnt_q != '0) ? rst_cnt_q - 16'd1 : rst_cnt_q;
        cpu_ce_d = state_q == RUN && !accept && carry && (ds_q || phase_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            phase_q <= 1'b0;
            ce_2x_q <= 1'b0;
            ce_q <= 1'b0;
            ce_n_q <= 1'b0;
            cpu_ce_q <= 1'b0;
            ds_q <= 1'b0;
            done_q <= 1'b0;
            stall_cnt_q <= '0;
            rst_cnt_q <= 16'(RST_TICKS);
        end else begin
            state_q <= state_d;
            phase_q <= phase_q ^ carry;
            ce_2x_q <= carry;
            ce_q <= carry & phase_q;
            ce_n_q <= carry & ~phase_q;
            cpu_ce_q <= cpu_ce_d;
            ds_q <= ds_d;
            done_q <= stall_end;
            stall_cnt_q <= stall_cnt_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign ce_2x = ce_2x_q;
    assign ce = ce_q;
    assign ce_n = ce_n_q;
    assign cpu_ce = cpu_ce_q;
    assign double_speed = ds_q;
    assign switch_done = done_q;
    assign gb_reset = rst_cnt_q != '0;
endmodule

// File: tb/tb_gb_clk_enable.sv
// tb_gb_clk_enable: random and directed stimulus against a carry-counting reference model.
module tb_gb_clk_enable;
    import gb_clk_pkg::*;
    localparam logic [31:0] INC_A = 32'h4000_0000;
    localparam int ST = 3, RT = 2, NB = 32400;

    logic clk = 1'b0, reset = 1'b1, pause = 1'b0, switch_req = 1'b0, reset_b = 1'b1;
    logic a_2x, a_ce, a_cen, a_cpu, a_ds, a_done, a_gbr;
    logic b_2x, b_ce, b_cen, b_cpu, b_ds, b_done, b_gbr;
    int n_chk = 0, n_fail = 0;

    gb_clk_enable #(.INC(INC_A), .STALL_TICKS(ST), .RST_TICKS(RT)) dut_a (
        .clk(clk), .reset(reset), .pause(pause), .switch_req(switch_req),
        .ce_2x(a_2x), .ce(a_ce), .ce_n(a_cen), .cpu_ce(a_cpu),
        .double_speed(a_ds), .switch_done(a_done), .gb_reset(a_gbr)
    );
    gb_clk_enable dut_b (
        .clk(clk), .reset(reset_b), .pause(1'b0), .switch_req(1'b0),
        .ce_2x(b_2x), .ce(b_ce), .ce_n(b_cen), .cpu_ce(b_cpu),
        .double_speed(b_ds), .switch_done(b_done), .gb_reset(b_gbr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: edge n carries iff floor(n*INC/2^32) advances; k-th carry is ce when k is even.
    longint unsigned m_n, m_k;
    int m_stall, m_rst, done_seen;
    logic m_ds, e_2x, e_ce, e_cen, e_cpu, e_done;

    task automatic model_step();
        logic c, prev_ce, acc;
        if (reset) begin
            m_n = 0; m_k = 0; m_stall = 0; m_rst = RT; m_ds = 0;
            {e_2x, e_ce, e_cen, e_cpu, e_done} = '0;
            return;
        end
        prev_ce = e_ce;
        c = 0;
        if (!pause) begin
            m_n++;
            c = ((m_n * INC_A) >> 32) != (((m_n - 1) * INC_A) >> 32);
        end
        if (c) m_k++;
        acc = m_stall == 0 && switch_req && m_rst == 0;
        e_2x = c;
        e_ce = c && m_k % 2 == 0;
        e_cen = c && m_k % 2 == 1;
        e_cpu = c && m_stall == 0 && !acc && (m_ds || m_k % 2 == 0);
        e_done = 0;
        if (m_stall > 0 && prev_ce) begin
            m_stall--;
            if (m_stall == 0) begin m_ds = ~m_ds; e_done = 1; end
        end
        if (acc) m_stall = ST;
        if (prev_ce && m_rst > 0) m_rst--;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("ce_2x", a_2x, e_2x);
        chk("ce", a_ce, e_ce);
        chk("ce_n", a_cen, e_cen);
        chk("cpu_ce", a_cpu, e_cpu);
        chk("double_speed", a_ds, m_ds);
        chk("switch_done", a_done, e_done);
        chk("gb_reset", a_gbr, m_rst > 0);
        if (a_done) done_seen++;
        switch_req = 1'b0;
    endtask

    int b_cnt2x = 0, b_cntce = 0;
    logic b_fin = 1'b0;
    initial begin
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        repeat (NB) begin
            @(negedge clk);
            b_cnt2x += int'(b_2x);
            b_cntce += int'(b_ce);
        end
        b_fin = 1'b1;
    end

    initial begin
        int first;
        longint unsigned exp2x;
        real ideal, diff;
        repeat (3) tick();
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) switch_req = 1'b1;
            tick();
            if (a_2x && first == 0) first = i;
        end
        chk("first_ce2x_edge", first, 4);
        repeat (16) tick();
        chk("ds_after_ignored_req", a_ds, 0);
        done_seen = 0;
        switch_req = 1'b1;
        repeat (40) tick();
        chk("ds_after_switch", a_ds, 1);
        chk("switch_done_pulses", done_seen, 1);
        for (int i = 0; i < 20 && !a_2x; i++) tick();
        chk("ce2x_before_pause", a_2x, 1);
        repeat (2) tick();
        pause = 1'b1;
        repeat (10) tick();
        pause = 1'b0;
        repeat (20) tick();
        switch_req = 1'b1;
        repeat (4) tick();
        switch_req = 1'b1;
        repeat (40) tick();
        switch_req = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("ds_after_reset", a_ds, 0);
        tick();
        switch_req = 1'b1;
        repeat (30) tick();
        chk("ds_req_in_stretch", a_ds, 0);
        repeat (600) begin
            pause = $urandom_range(3) == 0;
            reset = $urandom_range(299) == 0;
            switch_req = $urandom_range(39) == 0;
            tick();
        end
        reset = 1'b0; pause = 1'b0;
        for (int i = 0; i < 40000 && !b_fin; i++) @(negedge clk);
        chk("default_run_done", b_fin, 1);
        exp2x = (longint'(NB) * INC_2X) >> 32;
        chk("default_ce2x_exact", b_cnt2x, 32'(exp2x));
        chk("default_ce_exact", b_cntce, 32'(exp2x / 2));
        ideal = NB * 8.388608 / 64.8;
        diff = b_cnt2x - ideal;
        chk("default_ce2x_ppm", diff <= 1.0 && diff >= -1.0, 1);
        diff = b_cntce - ideal / 2.0;
        chk("default_ce_ppm", diff <= 1.0 && diff >= -1.0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
